// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single 16-bit memory port: instruction fetch (read-only)
// and data port (read/write), fixed wait states, registered data, one-cycle acks.
module mem_port_arbiter #(
  parameter int WAIT_STATES   = 0,
  parameter int MAX_DP_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        dp_req,
  input  logic        dp_we,
  input  logic [15:0] dp_addr,
  input  logic [15:0] dp_wdata,
  output logic        dp_ack,
  output logic [15:0] dp_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dp
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_STATES);
  localparam logic [3:0]    SMAX = 4'(MAX_DP_STREAK);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wcnt;
  logic [3:0]    streak;
  logic          win_dp, op_we;
  logic          if_elig, dp_elig, grant_if, grant_dp, last;

  // A requester is masked in its own ack cycle: its req still reflects the finished access.
  always_comb begin
    if_elig   = if_req & ~if_ack;
    dp_elig   = dp_req & ~dp_ack;
    grant_if  = 1'b0;
    grant_dp  = 1'b0;
    last      = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        grant_if = if_elig & (~dp_elig | (streak == SMAX));
        grant_dp = dp_elig & ~grant_if;
        if (grant_if | grant_dp) state_nxt = ACCESS;
      end
      ACCESS: begin
        last = (wcnt == LAST);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      streak    <= '0;
      win_dp    <= 1'b0;
      op_we     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      if_ack    <= 1'b0;
      dp_ack    <= 1'b0;
      if_rdata  <= '0;
      dp_rdata  <= '0;
    end else begin
      if_ack <= last & ~win_dp;
      dp_ack <= last & win_dp;
      mem_we <= 1'b0;
      if (grant_if | grant_dp) begin
        win_dp   <= grant_dp;
        op_we    <= grant_dp & dp_we;
        mem_addr <= grant_dp ? dp_addr : if_addr;
        if (grant_dp) mem_wdata <= dp_wdata;
        wcnt     <= '0;
        // mem_we is registered, so it is raised on the edge entering the final access cycle.
        mem_we   <= grant_dp & dp_we & (WAIT_STATES == 0);
        if (grant_dp & if_elig) begin
          if (streak != SMAX) streak <= streak + 4'd1;
        end else begin
          streak <= '0;
        end
      end else if ((state == ACCESS) && !last) begin
        wcnt   <= wcnt + CW'(1);
        mem_we <= op_we & ((wcnt + CW'(1)) == LAST);
      end
      if (last && !op_we) begin
        if (win_dp) dp_rdata <= mem_rdata;
        else        if_rdata <= mem_rdata;
      end
    end
  end

  assign stall_if = if_req & ~if_ack;
  assign stall_dp = dp_req & ~dp_ack;

endmodule
